mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 33 +++
 rtl/mc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle: IR fields and ALU flag in, control strobes and state out.
// master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [5:0]  OP;
    logic [5:0]  func;
    logic        zero;
    logic [2:0]  state;
    logic        PCWE;
    logic        IRWE;
    logic [1:0]  npcSel;
    logic        regWE;
    logic        memRE;
    logic        memWE;
    logic [1:0]  regDst;
    logic [1:0]  regStr;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic [1:0]  EXTOp;
    logic        illegal;
    logic [15:0] instr_cnt;

    modport master (
        input  OP, func, zero,
        output state, PCWE, IRWE, npcSel, regWE, memRE, memWE,
               regDst, regStr, ALUSrc, ALUOp, EXTOp, illegal, instr_cnt
    );

    modport slave (
        output OP, func, zero,
        input  state, PCWE, IRWE, npcSel, regWE, memRE, memWE,
               regDst, regStr, ALUSrc, ALUOp, EXTOp, illegal, instr_cnt
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM; FETCH-to-FETCH is 2 (jumps/illegal), 3 (beq), 4, or 5 (lw) cycles.
// Controls are combinational from the state register; there is no backpressure, and write strobes are gated by reset.
module mc_controller (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic r_type, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
    logic is_beq, is_lui, is_j, is_jal, is_illegal;

    assign r_type     = (bus.OP == 6'b000000);
    assign is_addu    = r_type && (bus.func == 6'b100001);
    assign is_subu    = r_type && (bus.func == 6'b100011);
    assign is_jr      = r_type && (bus.func == 6'b001000);
    assign is_ori     = (bus.OP == 6'b001101);
    assign is_lw      = (bus.OP == 6'b100011);
    assign is_sw      = (bus.OP == 6'b101011);
    assign is_beq     = (bus.OP == 6'b000100);
    assign is_lui     = (bus.OP == 6'b001111);
    assign is_j       = (bus.OP == 6'b000010);
    assign is_jal     = (bus.OP == 6'b000011);
    assign is_illegal = !(is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                          is_beq || is_lui || is_j || is_jal);

    logic       pcwe_c, irwe_c, regwe_c, memre_c, memwe_c, ill_c, alusrc_c;
    logic [1:0] npcsel_c, regdst_c, regstr_c, aluop_c, extop_c;

    always_comb begin
        state_d  = S_FETCH;
        pcwe_c   = 1'b0;
        irwe_c   = 1'b0;
        regwe_c  = 1'b0;
        memre_c  = 1'b0;
        memwe_c  = 1'b0;
        ill_c    = 1'b0;
        alusrc_c = 1'b0;
        npcsel_c = 2'b00;
        regdst_c = 2'b00;
        regstr_c = 2'b00;
        aluop_c  = 2'b00;
        extop_c  = 2'b00;
        case (state_q)
            S_DECODE: begin
                if (is_illegal) begin
                    ill_c = 1'b1;
                end else if (is_j) begin
                    pcwe_c   = 1'b1;
                    npcsel_c = 2'b10;
                end else if (is_jal) begin
                    pcwe_c   = 1'b1;
                    npcsel_c = 2'b10;
                    regwe_c  = 1'b1;
                    regdst_c = 2'b10;
                    regstr_c = 2'b10;
                end else if (is_jr) begin
                    pcwe_c   = 1'b1;
                    npcsel_c = 2'b11;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_addu || is_subu) begin
                    aluop_c = is_subu ? 2'b01 : 2'b00;
                    state_d = S_WB;
                end else if (is_ori) begin
                    alusrc_c = 1'b1;
                    aluop_c  = 2'b10;
                    state_d  = S_WB;
                end else if (is_lui) begin
                    alusrc_c = 1'b1;
                    extop_c  = 2'b01;
                    state_d  = S_WB;
                end else if (is_lw || is_sw) begin
                    alusrc_c = 1'b1;
                    extop_c  = 2'b10;
                    state_d  = S_MEM;
                end else if (is_beq) begin
                    aluop_c  = 2'b01;
                    extop_c  = 2'b10;
                    npcsel_c = 2'b01;
                    pcwe_c   = bus.zero;
                end
            end
            S_MEM: begin
                // Address operands stay on the ALU while memory is accessed.
                alusrc_c = 1'b1;
                extop_c  = 2'b10;
                if (is_lw) begin
                    memre_c = 1'b1;
                    state_d = S_WB;
                end else begin
                    memwe_c = is_sw;
                end
            end
            S_WB: begin
                regwe_c = 1'b1;
                if (is_addu || is_subu) begin
                    regdst_c = 2'b01;
                end else if (is_lw) begin
                    regstr_c = 2'b01;
                end
            end
            default: begin
                // FETCH, and unused encodings 5-7 which recover through FETCH behaviour.
                irwe_c  = 1'b1;
                pcwe_c  = 1'b1;
                state_d = S_DECODE;
            end
        endcase
    end

    // Any transition back to FETCH retires the instruction unless it was undecodable.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_FETCH) && !ill_c) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;
    assign bus.PCWE      = pcwe_c  & reset;
    assign bus.IRWE      = irwe_c  & reset;
    assign bus.regWE     = regwe_c & reset;
    assign bus.memRE     = memre_c & reset;
    assign bus.memWE     = memwe_c & reset;
    assign bus.illegal   = ill_c   & reset;
    assign bus.npcSel    = npcsel_c;
    assign bus.regDst    = regdst_c;
    assign bus.regStr    = regstr_c;
    assign bus.ALUSrc    = alusrc_c;
    assign bus.ALUOp     = aluop_c;
    assign bus.EXTOp     = extop_c;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-state control checks for lw, beq, jal, illegal, sw-under-reset and counter wrap.
module tb_mc_controller;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;
    logic [15:0] exp_cnt;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.OP   = op;
        bus.func = fn;
        bus.zero = z;
    endtask

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        exp_cnt = 16'd0;
        reset   = 1'b0;
        set_instr(6'b000000, 6'b000000, 1'b0);

        // Reset state
        #2;
        check("rst_state", bus.state, 0);
        check("rst_cnt",   bus.instr_cnt, 0);
        check("rst_irwe",  bus.IRWE, 0);
        check("rst_pcwe",  bus.PCWE, 0);
        check("rst_ill",   bus.illegal, 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_state", bus.state, 0);
        check("post_rst_irwe",  bus.IRWE, 1);
        check("post_rst_pcwe",  bus.PCWE, 1);

        // lw
        set_instr(6'b100011, 6'b000000, 1'b0);
        check("lw_f_npc",   bus.npcSel, 0);
        check("lw_f_memre", bus.memRE, 0);
        step();
        check("lw_d_state", bus.state, 1);
        check("lw_d_regwe", bus.regWE, 0);
        step();
        check("lw_e_state", bus.state, 2);
        check("lw_e_alusrc", bus.ALUSrc, 1);
        check("lw_e_extop", bus.EXTOp, 2);
        check("lw_e_aluop", bus.ALUOp, 0);
        check("lw_e_memre", bus.memRE, 0);
        step();
        check("lw_m_state", bus.state, 3);
        check("lw_m_memre", bus.memRE, 1);
        check("lw_m_regwe", bus.regWE, 0);
        check("lw_m_alusrc", bus.ALUSrc, 1);
        step();
        check("lw_w_state", bus.state, 4);
        check("lw_w_regwe", bus.regWE, 1);
        check("lw_w_regstr", bus.regStr, 1);
        check("lw_w_regdst", bus.regDst, 0);
        check("lw_w_memre", bus.memRE, 0);
        step();
        exp_cnt = exp_cnt + 16'd1;
        check("lw_done_state", bus.state, 0);
        check("lw_cnt", bus.instr_cnt, 32'(exp_cnt));

        // beq taken and not taken
        for (int k = 1; k >= 0; k--) begin
            set_instr(6'b000100, 6'b000000, k[0]);
            step();
            check("beq_d_state", bus.state, 1);
            step();
            check("beq_e_state", bus.state, 2);
            check("beq_e_pcwe", bus.PCWE, 32'(k));
            check("beq_e_npc", bus.npcSel, 1);
            check("beq_e_aluop", bus.ALUOp, 1);
            check("beq_e_extop", bus.EXTOp, 2);
            step();
            exp_cnt = exp_cnt + 16'd1;
            check("beq_done_state", bus.state, 0);
            check("beq_cnt", bus.instr_cnt, 32'(exp_cnt));
        end

        // jal
        set_instr(6'b000011, 6'b000000, 1'b0);
        step();
        check("jal_d_state", bus.state, 1);
        check("jal_d_pcwe", bus.PCWE, 1);
        check("jal_d_npc", bus.npcSel, 2);
        check("jal_d_regwe", bus.regWE, 1);
        check("jal_d_regdst", bus.regDst, 2);
        check("jal_d_regstr", bus.regStr, 2);
        step();
        exp_cnt = exp_cnt + 16'd1;
        check("jal_done_state", bus.state, 0);
        check("jal_cnt", bus.instr_cnt, 32'(exp_cnt));

        // Unsupported R-type (add, funct 100000)
        set_instr(6'b000000, 6'b100000, 1'b0);
        check("ill_f_flag", bus.illegal, 0);
        step();
        check("ill_d_state", bus.state, 1);
        check("ill_d_flag", bus.illegal, 1);
        check("ill_d_pcwe", bus.PCWE, 0);
        check("ill_d_irwe", bus.IRWE, 0);
        check("ill_d_regwe", bus.regWE, 0);
        check("ill_d_memwe", bus.memWE, 0);
        check("ill_d_memre", bus.memRE, 0);
        step();
        check("ill_done_state", bus.state, 0);
        check("ill_done_flag", bus.illegal, 0);
        check("ill_cnt", bus.instr_cnt, 32'(exp_cnt));

        // addu: 0,1,2,4,0
        set_instr(6'b000000, 6'b100001, 1'b0);
        step();
        step();
        check("addu_e_state", bus.state, 2);
        check("addu_e_alusrc", bus.ALUSrc, 0);
        check("addu_e_aluop", bus.ALUOp, 0);
        step();
        check("addu_w_state", bus.state, 4);
        check("addu_w_regwe", bus.regWE, 1);
        check("addu_w_regdst", bus.regDst, 1);
        check("addu_w_regstr", bus.regStr, 0);
        step();
        exp_cnt = exp_cnt + 16'd1;
        check("addu_cnt", bus.instr_cnt, 32'(exp_cnt));

        // sw abandoned by reset as it enters MEM
        set_instr(6'b101011, 6'b000000, 1'b0);
        step();
        step();
        check("sw_e_state", bus.state, 2);
        check("sw_e_memwe", bus.memWE, 0);
        @(posedge clk);
        reset = 1'b0;
        #1;
        check("sw_rst_memwe", bus.memWE, 0);
        check("sw_rst_state", bus.state, 0);
        check("sw_rst_cnt", bus.instr_cnt, 0);
        @(negedge clk);
        check("sw_rst_hold_memwe", bus.memWE, 0);
        check("sw_rst_hold_state", bus.state, 0);
        reset   = 1'b1;
        exp_cnt = 16'd0;
        #1;
        check("rerst_irwe", bus.IRWE, 1);
        check("rerst_pcwe", bus.PCWE, 1);
        check("rerst_state", bus.state, 0);

        // Counter wrap: preload 65535 retirements, then one addu
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap_preload", bus.instr_cnt, 32'hFFFF);
        set_instr(6'b000000, 6'b100001, 1'b0);
        step();
        step();
        step();
        check("wrap_w_state", bus.state, 4);
        check("wrap_w_cnt", bus.instr_cnt, 32'hFFFF);
        step();
        check("wrap_state", bus.state, 0);
        check("wrap_cnt", bus.instr_cnt, 32'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
